echo_indication_input: RTL and testbench

Receive-side endpoint of the Echo indication channel. Accepts 96-bit packed indication messages from the transport pipe, decodes the tag word, and replays valid messages as `heard(meth, v)` method calls toward the software-facing indication interface. A 2-entry FIFO decouples the pipe from the consumer so that `enq__RDY` never depends combinationally on `heard__RDY`. Messages with an unrecognised tag are discarded and counted.

---
 rtl/echo_indication_input.sv | 80 ++++++++
 tb/tb_echo_indication_input.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/echo_indication_input.sv
// Receive-side endpoint of the Echo indication channel: decodes packed pipe messages
// and replays valid ones as heard(meth, v) calls through a 2-entry FIFO.
module echo_indication_input #(
  parameter logic [31:0] HEARD_TAG = 32'd1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enq__ENA,
  input  logic [95:0] enq_v,
  output logic        enq__RDY,
  output logic        heard__ENA,
  output logic [31:0] heard_meth,
  output logic [31:0] heard_v,
  input  logic        heard__RDY,
  output logic [15:0] drop_count
);

  logic [31:0] r_meth [2];
  logic [31:0] r_v    [2];
  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  logic [15:0] r_drop;

  logic w_enq_fire;
  logic w_tag_ok;
  logic w_push;
  logic w_bad;
  logic w_pop;

  // Readiness comes from registered occupancy only, so the pipe never sees heard__RDY.
  assign enq__RDY   = (r_count != 2'd2);
  assign heard__ENA = (r_count != 2'd0);
  assign heard_meth = r_meth[r_rptr];
  assign heard_v    = r_v[r_rptr];
  assign drop_count = r_drop;

  assign w_enq_fire = enq__ENA && enq__RDY;
  assign w_tag_ok   = (enq_v[31:0] == HEARD_TAG);
  assign w_push     = w_enq_fire && w_tag_ok;
  assign w_bad      = w_enq_fire && !w_tag_ok;
  assign w_pop      = heard__ENA && heard__RDY;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_meth[0] <= '0;
      r_meth[1] <= '0;
      r_v[0]    <= '0;
      r_v[1]    <= '0;
    end else if (w_push) begin
      r_meth[r_wptr] <= enq_v[63:32];
      r_v[r_wptr]    <= enq_v[95:64];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_drop <= '0;
    end else if (w_bad && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

endmodule

// File: tb/tb_echo_indication_input.sv
// Bench for echo_indication_input: directed scenarios plus random traffic checked
// against a queue-based model of the channel.
module tb_echo_indication_input;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        enq__ENA = 1'b0;
  logic [95:0] enq_v = '0;
  logic        enq__RDY;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY = 1'b0;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  int unsigned mdrop = 0;

  echo_indication_input #(.HEARD_TAG(32'd1)) dut (
    .CLK(CLK), .nRST(nRST), .enq__ENA(enq__ENA), .enq_v(enq_v), .enq__RDY(enq__RDY),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
    .heard__RDY(heard__RDY), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [95:0] msg(input logic [31:0] tag, input logic [31:0] meth,
                                      input logic [31:0] v);
    return {v, meth, tag};
  endfunction

  // Channel behaviour: capacity 2, readiness from pre-edge occupancy, bad tags counted.
  function automatic void model_step(input logic ena, input logic [95:0] d, input logic rdy);
    bit can_enq;
    can_enq = (mq.size() != 2);
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (ena && can_enq) begin
      if (d[31:0] == 32'd1) mq.push_back({d[63:32], d[95:64]});
      else if (mdrop != 65535) mdrop++;
    end
  endfunction

  task automatic cyc(input logic ena, input logic [95:0] d, input logic rdy);
    enq__ENA   = ena;
    enq_v      = d;
    heard__RDY = rdy;
    model_step(ena, d, rdy);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    enq__ENA = 1'b0;
    enq_v = '0;
    heard__RDY = 1'b0;
    mq.delete();
    mdrop = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (enq__RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", enq__RDY); end
    checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b expected 0", heard__ENA); end
    checks++; if (heard_meth !== 32'd0 || heard_v !== 32'd0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", heard_meth, heard_v); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %h expected 0", drop_count); end
  endtask

  task automatic test_single();
    do_reset();
    cyc(1'b1, msg(32'd1, 32'h5, 32'hDEADBEEF), 1'b1);
    checks++; if (heard__ENA !== 1'b1) begin errors++; $display("FAIL single_ena: got %b expected 1", heard__ENA); end
    checks++; if (heard_meth !== 32'h5 || heard_v !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h/%h expected 5/deadbeef", heard_meth, heard_v); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL single_once: got %b expected 0", heard__ENA); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL single_drop: got %h expected 0", drop_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    checks++; if (enq__RDY !== 1'b1) begin errors++; $display("FAIL bp_rdy1: got %b expected 1", enq__RDY); end
    cyc(1'b1, msg(32'd1, 32'h10, 32'd1), 1'b0);
    checks++; if (enq__RDY !== 1'b1) begin errors++; $display("FAIL bp_rdy2: got %b expected 1", enq__RDY); end
    cyc(1'b1, msg(32'd1, 32'h11, 32'd2), 1'b0);
    checks++; if (enq__RDY !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", enq__RDY); end
    cyc(1'b1, msg(32'd1, 32'h12, 32'd3), 1'b0);
    // Full with v=3 still offered: enqueue refused while the first call drains.
    checks++; if (enq__RDY !== 1'b0 || heard__ENA !== 1'b1 || heard_v !== 32'd1) begin errors++; $display("FAIL bp_deq1: got rdy=%b ena=%b v=%0d expected rdy=0 ena=1 v=1", enq__RDY, heard__ENA, heard_v); end
    cyc(1'b1, msg(32'd1, 32'h12, 32'd3), 1'b1);
    checks++; if (enq__RDY !== 1'b1 || heard_v !== 32'd2) begin errors++; $display("FAIL bp_deq2: got rdy=%b v=%0d expected rdy=1 v=2", enq__RDY, heard_v); end
    cyc(1'b1, msg(32'd1, 32'h12, 32'd3), 1'b1);
    checks++; if (heard__ENA !== 1'b1 || heard_v !== 32'd3 || heard_meth !== 32'h12) begin errors++; $display("FAIL bp_deq3: got ena=%b v=%0d meth=%h expected ena=1 v=3 meth=12", heard__ENA, heard_v, heard_meth); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", heard__ENA); end
  endtask

  task automatic test_stream();
    int seen = 0;
    do_reset();
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        checks++;
        if (heard__ENA !== 1'b1 || heard_v !== 32'(i) || enq__RDY !== 1'b1) begin
          errors++; $display("FAIL stream_%0d: got ena=%b v=%0d rdy=%b expected ena=1 v=%0d rdy=1", i, heard__ENA, heard_v, enq__RDY, i);
        end else seen++;
      end
      if (i < 100) cyc(1'b1, msg(32'd1, $urandom, 32'(i + 1)), 1'b1);
      else cyc(1'b0, '0, 1'b1);
    end
    checks++; if (seen != 100 || heard__ENA !== 1'b0) begin errors++; $display("FAIL stream_total: got %0d calls ena=%b expected 100 ena=0", seen, heard__ENA); end
  endtask

  task automatic test_bad_tag();
    do_reset();
    cyc(1'b1, msg(32'd1, 32'h1, 32'hA), 1'b1);
    checks++; if (heard__ENA !== 1'b1 || heard_v !== 32'hA) begin errors++; $display("FAIL bad_first: got ena=%b v=%h expected 1/a", heard__ENA, heard_v); end
    cyc(1'b1, msg(32'd7, 32'd9, 32'hBAD), 1'b1);
    checks++; if (heard__ENA !== 1'b0 || drop_count !== 16'd1) begin errors++; $display("FAIL bad_dropped: got ena=%b drop=%0d expected 0/1", heard__ENA, drop_count); end
    cyc(1'b1, msg(32'd1, 32'h2, 32'hB), 1'b1);
    checks++; if (heard__ENA !== 1'b1 || heard_v !== 32'hB) begin errors++; $display("FAIL bad_second: got ena=%b v=%h expected 1/b", heard__ENA, heard_v); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (heard__ENA !== 1'b0 || drop_count !== 16'(mdrop)) begin errors++; $display("FAIL bad_end: got ena=%b drop=%0d expected 0/%0d", heard__ENA, drop_count, mdrop); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65534; i++) cyc(1'b1, msg(32'd3, 32'd0, 32'd0), 1'b1);
    checks++; if (drop_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", drop_count); end
    cyc(1'b1, msg(32'd0, 32'd0, 32'd0), 1'b1);
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", drop_count); end
    cyc(1'b1, msg(32'hFFFF_FFFF, 32'd0, 32'd0), 1'b0);
    checks++; if (drop_count !== 16'hFFFF || enq__RDY !== 1'b1) begin errors++; $display("FAIL sat_hold: got drop=%h rdy=%b expected ffff/1", drop_count, enq__RDY); end
  endtask

  task automatic test_random();
    logic        ena, rdy;
    logic [31:0] tag;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (enq__RDY !== (mq.size() != 2) || heard__ENA !== (mq.size() != 0) ||
          drop_count !== 16'(mdrop) ||
          (mq.size() != 0 && {heard_meth, heard_v} !== mq[0])) begin
        errors++;
        $display("FAIL random_%0d: got rdy=%b ena=%b drop=%0d data=%h/%h expected size=%0d drop=%0d", i, enq__RDY, heard__ENA, drop_count, heard_meth, heard_v, mq.size(), mdrop);
      end
      ena = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      tag = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 9) : 32'd1;
      cyc(ena, msg(tag, $urandom, $urandom), rdy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b1, msg(32'd5, 32'd0, 32'd0), 1'b0);
    cyc(1'b1, msg(32'd1, 32'h21, 32'h1111), 1'b0);
    cyc(1'b1, msg(32'd1, 32'h22, 32'h2222), 1'b0);
    checks++; if (heard__ENA !== 1'b1 || drop_count !== 16'd1 || enq__RDY !== 1'b0) begin errors++; $display("FAIL arst_pre: got ena=%b drop=%0d rdy=%b expected 1/1/0", heard__ENA, drop_count, enq__RDY); end
    enq__ENA = 1'b0;
    #2 nRST = 1'b0;
    #1;
    checks++; if (heard__ENA !== 1'b0 || drop_count !== 16'd0 || enq__RDY !== 1'b1 || heard_v !== 32'd0) begin errors++; $display("FAIL arst_now: got ena=%b drop=%0d rdy=%b v=%h expected 0/0/1/0", heard__ENA, drop_count, enq__RDY, heard_v); end
    @(negedge CLK);
    nRST = 1'b1;
    mq.delete();
    mdrop = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (heard__ENA !== 1'b0 || enq__RDY !== 1'b1) begin errors++; $display("FAIL arst_after_%0d: got ena=%b rdy=%b expected 0/1", i, heard__ENA, enq__RDY); end
      cyc(1'b0, '0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_bad_tag();
    test_random();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
